modular_multiplication: RTL and testbench
=========================================

# modular_multiplication

- Computes `result = (A * B) mod p` on WIDTH-bit operands.
- Uses MSB-first interleaved shift-and-add with conditional subtraction, one multiplier bit per clock.
- Sits directly downstream of the modular adder in the elliptic-curve point-arithmetic datapath.
- Consumes reduced field elements (sums and stored coordinates) and produces the field products the point-addition sequencer needs.
- Uses the same level-held `i_start` / `done` handshake as the adder, so the sequencer drives both blocks identically.

## Interface
- `WIDTH`, default 256: operand, modulus and result width in bits.
- `i_clk`, input, 1: single clock; all state updates on the rising edge.
- `i_rst`, input, 1: reset, asynchronous and active-high.
- `i_start`, input, 1: level request; held high until `done` is seen, then dropped.
- `A`, input, WIDTH: multiplicand; precondition `A < p`.
- `B`, input, WIDTH: multiplier, scanned MSB first; precondition `B < p`.
- `p`, input, WIDTH: modulus; precondition `p >= 2`.
- `result`, output, WIDTH: registered product mod p; valid while `done` is high.
- `done`, output, 1: registered completion flag.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `done` = 0.
  - On an edge with `i_start` = 1: latch A, B and p into internal registers; clear accumulator R (WIDTH+1 bits); load bit index `cnt` = WIDTH-1; go to RUN.
  - Inputs are not sampled again until the next IDLE exit, so A, B and p may change after the latch edge.
- **RUN, one iteration per edge:**
  - T = 2R; if T >= p then T = T - p.
  - If B_lat[cnt] = 1 then T = T + A_lat; if T >= p then T = T - p.
  - R <= T.
  - If `cnt` = 0: `result` <= T[WIDTH-1:0]; go to DONE. Otherwise `cnt` <= `cnt` - 1.
- **DONE:**
  - `done` = 1; `result` is held.
  - When `i_start` = 0 on an edge, go to IDLE; `done` falls and `result` keeps its value.
  - `i_start` held high keeps DONE indefinitely; there is no auto-restart.
- **Width rules:**
  - Invariant R < p after every iteration.
  - 2R and R + A both stay below 2p < 2^(WIDTH+1), so WIDTH+1-bit intermediates suffice.
  - Comparisons and subtractions are done at WIDTH+1 bits; no carry is dropped.
- **Out-of-range inputs** (A >= p, B >= p, or p < 2):
  - The result value is unspecified.
  - Timing is unchanged, `done` still asserts on schedule, and no X propagates from internal registers.
- **`i_start` deasserted during RUN:** ignored. The operation completes and DONE is entered, then exits on the next edge because `i_start` = 0.

## Timing
- **Reset values** (asynchronous, immediate on `i_rst` high): state = IDLE; `done` = 0; `result` = 0; R, `cnt`, A_lat, B_lat, p_lat = 0.
- **Reset mid-RUN:** aborts immediately. After reset releases, the block is in IDLE and needs a fresh `i_start` high.
- **Latency:**
  - `i_start` sampled high at edge k: RUN iterations run on edges k+1 through k+WIDTH.
  - `done` is high after edge k+WIDTH, i.e. 257 cycles for WIDTH = 256.
- **Handshake:**
  - `i_start` high at edge j while in DONE: stays in DONE.
  - `i_start` low at edge j: IDLE after edge j.
  - Earliest back-to-back restart: `i_start` low for exactly one edge, then high.
- **Throughput:** one product per WIDTH+2 cycles minimum.

## Structure
- **Shared package `ecpa_pkg`** holds:
  - the `WIDTH` = 256 default constant;
  - the `modmul_state_t` enum (IDLE, RUN, DONE);
  - the field-modulus constant `P_SECP256K1` = 0xFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, shared by the adder bench and this bench.
- **Sub-module `modmul_step`:** purely combinational single-iteration datapath.
  - Inputs: R, A, p, bit.
  - Output: next R.
  - Contains the doubling, conditional add and the two conditional subtractors.
- **Top level:** the FSM, counter and registers; instantiates one `modmul_step`.

## Test plan
- **Small values:** p = 7, A = 3, B = 5, WIDTH = 256 → `result` = 1, `done` high exactly 257 cycles after the `i_start` latch edge.
- **Power-of-two modulus:** p = 0x100, A = 0xff, B = 0x20 → `result` = 0xe0.
- **Maximum operands:** p = `P_SECP256K1`, A = B = p-1 → `result` = 1.
- **Zero operand:** A = 0, any B < p → `result` = 0. Also checked with B = 0.
- **Reset mid-operation:** assert `i_rst` for one cycle at iteration 100 → `done` = 0 and `result` = 0 immediately; a new start then gives the correct product with full latency.
- **Handshake:** hold `i_start` high for 50 cycles after `done` → `done` and `result` stay stable. Drop `i_start` for one cycle, then raise it with new operands → second product correct, and `done` is low throughout the second RUN.

Source files
------------

// File: rtl/ecpa_pkg.sv
// Shared definitions for the elliptic-curve point-arithmetic datapath:
// default field width, modular multiplier state encoding, secp256k1 modulus.
package ecpa_pkg;

  localparam int WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } modmul_state_t;

  localparam logic [255:0] P_SECP256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

endpackage

// File: rtl/modular_multiplication_if.sv
// Request/response bundle between the point-addition sequencer and the
// modular multiplier: level-held start, operands, registered product.
interface modular_multiplication_if #(
  parameter int WIDTH = ecpa_pkg::WIDTH
) ();

  logic             i_start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] result;
  logic             done;

  modport master (output i_start, A, B, p, input result, done);
  modport slave  (input i_start, A, B, p, output result, done);

endinterface

// File: rtl/modmul_step.sv
// One MSB-first interleaved iteration: R' = (2R + bit*A) mod p.
// All arithmetic is WIDTH+1 bits wide so 2R and R+A never lose a carry
// while the invariant R < p holds.
module modmul_step #(
  parameter int WIDTH = ecpa_pkg::WIDTH
) (
  input  logic [WIDTH:0]   r,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  input  logic             b_bit,
  output logic [WIDTH:0]   r_next
);

  logic [WIDTH:0] p_ext;
  logic [WIDTH:0] t_dbl;
  logic [WIDTH:0] t_dbl_red;
  logic [WIDTH:0] t_add;

  assign p_ext = {1'b0, p};

  // double, reduce once, conditionally add A, reduce once more
  always_comb begin
    t_dbl     = r + r;
    t_dbl_red = (t_dbl >= p_ext) ? (t_dbl - p_ext) : t_dbl;
    t_add     = b_bit ? (t_dbl_red + {1'b0, a}) : t_dbl_red;
    r_next    = (t_add >= p_ext) ? (t_add - p_ext) : t_add;
  end

endmodule

// File: rtl/modular_multiplication.sv
// Iterative modular multiplier, result = (A * B) mod p, one multiplier bit
// per clock, MSB first. Operands are latched on the start edge so the
// sequencer may change them while the product is being formed.
//
// state | meaning
// IDLE  | waiting for i_start; done low
// RUN   | one modmul_step iteration per edge, cnt walks WIDTH-1 down to 0
// DONE  | product valid on result; leave once i_start is dropped
module modular_multiplication
  import ecpa_pkg::*;
#(
  parameter int WIDTH = ecpa_pkg::WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  modular_multiplication_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  modmul_state_t    state;
  modmul_state_t    state_next;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] p_lat;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH:0]   r_next;
  logic [CW-1:0]    cnt;

  modmul_step #(.WIDTH(WIDTH)) u_step (
    .r      (r_q),
    .a      (a_lat),
    .p      (p_lat),
    .b_bit  (b_lat[cnt]),
    .r_next (r_next)
  );

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // next-state decode; start is ignored during RUN
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_start) state_next = RUN;
      RUN:     if (cnt == '0)   state_next = DONE;
      DONE:    if (!bus.i_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // operand latch, accumulator, bit index and result register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_lat    <= '0;
      b_lat    <= '0;
      p_lat    <= '0;
      r_q      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            a_lat <= bus.A;
            b_lat <= bus.B;
            p_lat <= bus.p;
            r_q   <= '0;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        RUN: begin
          r_q <= r_next;
          if (cnt == '0) result_q <= r_next[WIDTH-1:0];
          else           cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_modular_multiplication.sv
// Directed bench for modular_multiplication with hand-computed products.
module tb_modular_multiplication;
  import ecpa_pkg::*;

  localparam int W   = ecpa_pkg::WIDTH;
  localparam int LAT = W + 1;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  modular_multiplication_if #(.WIDTH(W)) bus ();

  modular_multiplication #(.WIDTH(W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  // Start an operation and wait for done. cyc counts edges from the latch
  // edge (1) to the edge after which done is seen; 0 means timeout.
  // Operands are scrambled right after the latch edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input bit drop,
                        output logic [W-1:0] res, output int cyc);
    @(negedge i_clk);
    bus.A = a; bus.B = b; bus.p = m; bus.i_start = 1'b1;
    @(posedge i_clk);
    cyc = 1;
    #1;
    bus.A = ~a; bus.B = ~b; bus.p = ~m;
    if (drop) bus.i_start = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(posedge i_clk);
      cyc++;
      #1;
      if (bus.done) break;
    end
    if (bus.done !== 1'b1) cyc = 0;
    res = bus.result;
  endtask

  task automatic release_start();
    @(negedge i_clk);
    bus.i_start = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] m,
                          input logic [W-1:0] exp);
    logic [W-1:0] res;
    int cyc;
    run_op(a, b, m, 1'b0, res, cyc);
    checks++;
    if (res !== exp) begin
      failures++;
      $display("FAIL %s result: got %0h expected %0h", name, res, exp);
    end
    checks++;
    if (cyc != LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT);
    end
    release_start();
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0; bus.A = '0; bus.B = '0; bus.p = '0;
    #2;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== '0) begin
      failures++;
      $display("FAIL reset_state: done=%b result=%0h expected done=0 result=0",
               bus.done, bus.result);
    end
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_small();
    check_op("small_3x5_mod7", W'(3), W'(5), W'(7), W'(1));
    check_op("13_12x11", W'(12), W'(11), W'(13), W'(2));
    check_op("97_50x60", W'(50), W'(60), W'(97), W'(90));
  endtask

  task automatic test_pow2();
    check_op("pow2_mod", W'(8'hff), W'(8'h20), W'(16'h100), W'(8'he0));
  endtask

  task automatic test_max();
    check_op("secp_max", P_SECP256K1 - 1, P_SECP256K1 - 1, P_SECP256K1, W'(1));
    check_op("mod7_max", W'(6), W'(6), W'(7), W'(1));
  endtask

  task automatic test_zero();
    check_op("zero_a", W'(0), W'(5), W'(7), W'(0));
    check_op("zero_b", W'(5), W'(0), W'(7), W'(0));
  endtask

  task automatic test_start_drop();
    logic [W-1:0] res;
    int cyc;
    run_op(W'(4), W'(6), W'(7), 1'b1, res, cyc);
    checks++;
    if (res !== W'(3) || cyc != LAT) begin
      failures++;
      $display("FAIL drop_start_run: result=%0h cyc=%0d expected 3 and %0d",
               res, cyc, LAT);
    end
    @(posedge i_clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== W'(3)) begin
      failures++;
      $display("FAIL drop_start_exit: done=%b result=%0h expected 0 and 3",
               bus.done, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res;
    int cyc;
    int bad;
    run_op(W'(12), W'(11), W'(13), 1'b0, res, cyc);
    checks++;
    if (res !== W'(2) || cyc != LAT) begin
      failures++;
      $display("FAIL hs_first: result=%0h cyc=%0d expected 2 and %0d", res, cyc, LAT);
    end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge i_clk);
      bus.A = W'($urandom); bus.B = W'($urandom); bus.p = W'($urandom);
      @(posedge i_clk);
      #1;
      if (bus.done !== 1'b1 || bus.result !== W'(2)) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hs_hold: %0d unstable cycles, expected 0", bad);
    end
    release_start();
    checks++;
    if (bus.done !== 1'b0 || bus.result !== W'(2)) begin
      failures++;
      $display("FAIL hs_release: done=%b result=%0h expected 0 and 2",
               bus.done, bus.result);
    end
    run_op(W'(50), W'(60), W'(97), 1'b0, res, cyc);
    checks++;
    if (res !== W'(90) || cyc != LAT) begin
      failures++;
      $display("FAIL hs_second: result=%0h cyc=%0d expected 90 and %0d", res, cyc, LAT);
    end
    release_start();
  endtask

  task automatic test_reset_mid();
    @(negedge i_clk);
    bus.A = W'(3); bus.B = W'(5); bus.p = W'(7); bus.i_start = 1'b1;
    @(posedge i_clk);
    repeat (100) @(posedge i_clk);
    #1;
    bus.i_start = 1'b0;
    i_rst = 1'b1;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== '0) begin
      failures++;
      $display("FAIL mid_reset: done=%b result=%0h expected 0 and 0",
               bus.done, bus.result);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle: done=%b expected 0", bus.done);
    end
    check_op("after_reset_7x9_mod11", W'(7), W'(9), W'(11), W'(8));
  endtask

  initial begin
    test_reset();
    test_small();
    test_pow2();
    test_max();
    test_zero();
    test_start_drop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
